// File: rtl/bsg_test_node_master.sv
// -----------------------------------------------------------------------------
// bsg_test_node_master
//
// Test master for one client on a packet ring. A test runs in this order:
//   1. Stream num_tx_p stimulus words from the host to the client. Each word is
//      wrapped into a ring packet {zeros, client_id_p[3:0], stim_data}. There
//      is no register on this path.
//   2. Consume num_rx_p responses from the client. Each response is taken
//      together with one host expected word, and the two are compared. The
//      comparison covers the payload and the 4-bit client ID field.
//   3. Stop in DONE and report status until the next reset.
// If the gap between two responses reaches timeout_p enabled cycles, the test
// ends early with timeout_o set.
//
// Ports
//   clk_i, reset_n_i             : clock; async active-low reset. The reset
//                                  asserts at once and releases in step
//                                  with clk_i.
//   en_i                         : global enable. When low, all state is held
//                                  and every handshake output is low.
//   stim_v_i/stim_data_i/stim_ready_o : host stimulus stream (valid-ready)
//   exp_v_i/exp_data_i/exp_ready_o    : host expected-response stream
//   v_o/data_o/ready_i           : packets to the client (valid-ready)
//   v_i/data_i/yumi_o            : packets from the client (valid-yumi)
//   done_o/pass_o/timeout_o      : test status
//   error_count_o                : count of mismatched responses,
//                                  saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module bsg_test_node_master #(
    parameter int ring_width_p = 80,
    parameter int client_id_p  = 0,
    parameter int num_tx_p     = 64,
    parameter int num_rx_p     = 64,
    parameter int timeout_p    = 4096
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    en_i,

    input  logic                    stim_v_i,
    input  logic [74:0]             stim_data_i,
    output logic                    stim_ready_o,

    input  logic                    exp_v_i,
    input  logic [74:0]             exp_data_i,
    output logic                    exp_ready_o,

    output logic                    v_o,
    output logic [ring_width_p-1:0] data_o,
    input  logic                    ready_i,

    input  logic                    v_i,
    input  logic [ring_width_p-1:0] data_i,
    output logic                    yumi_o,

    output logic                    done_o,
    output logic                    pass_o,
    output logic                    timeout_o,
    output logic [15:0]             error_count_o
);

    localparam logic [3:0] client_id_lp = 4'(client_id_p);
    localparam int         tx_w_lp      = $clog2(num_tx_p + 1);
    localparam int         rx_w_lp      = $clog2(num_rx_p + 1);
    localparam int         tmo_w_lp     = $clog2(timeout_p + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } state_e;

    // -------------------------------------------------------------------------
    // Reset synchronizer. The reset asserts asynchronously, so the outputs drop
    // with no clock edge. It releases only after two clk_i edges, so the FSM
    // never leaves reset in the middle of a clock period.
    // -------------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic [1:0] rst_sync_d;
    logic       rst_n;

    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    // NOTE: flops assign only with <= so every flop samples pre-edge values;
    // combinational blocks use = so later lines see the freshly computed value.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) rst_sync_q <= '0;
        else            rst_sync_q <= rst_sync_d;
    end

    assign rst_n = rst_sync_q[1];

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e              state_q,    state_d;
    logic [tx_w_lp-1:0]  tx_count_q, tx_count_d;
    logic [rx_w_lp-1:0]  rx_count_q, rx_count_d;
    logic [tmo_w_lp-1:0] timer_q,    timer_d;
    logic [15:0]         err_q,      err_d;
    logic                timeout_q,  timeout_d;

    // NOTE: every flop here is a plain control register (no memories), so all
    // of them are cleared by reset; that is what guarantees an aborted test
    // leaves no partial status behind.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_count_q <= '0;
            rx_count_q <= '0;
            timer_q    <= '0;
            err_q      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_count_q <= tx_count_d;
            rx_count_q <= rx_count_d;
            timer_q    <= timer_d;
            err_q      <= err_d;
            timeout_q  <= timeout_d;
        end
    end

    // -------------------------------------------------------------------------
    // Packet formatting. Bits above the ID field are always zero. The word is
    // passed through in every state; only v_o says whether it is meaningful.
    // -------------------------------------------------------------------------
    always_comb begin
        data_o       = '0;
        data_o[78:0] = {client_id_lp, stim_data_i};
    end

    // Bits of data_i above the ID field carry nothing for this master.
    if (ring_width_p > 79) begin : g_unused_hi
        logic unused_data_hi;
        assign unused_data_hi = ^data_i[ring_width_p-1:79];
    end

    // -------------------------------------------------------------------------
    // Next-state and handshake logic
    // -------------------------------------------------------------------------
    logic stim_fire;
    logic resp_fire;
    logic mismatch;

    always_comb begin
        // NOTE: every output of this block gets a default before the case, so
        // no path leaves a signal unassigned and no latch is inferred.
        state_d      = state_q;
        tx_count_d   = tx_count_q;
        rx_count_d   = rx_count_q;
        timer_d      = timer_q;
        err_d        = err_q;
        timeout_d    = timeout_q;
        v_o          = 1'b0;
        stim_ready_o = 1'b0;
        yumi_o       = 1'b0;
        exp_ready_o  = 1'b0;
        stim_fire    = 1'b0;
        resp_fire    = 1'b0;
        mismatch     = (data_i[74:0] != exp_data_i)
                     | (data_i[78:75] != client_id_lp);

        unique case (state_q)
            IDLE: begin
                if (en_i) state_d = SEND;
            end

            SEND: begin
                v_o          = en_i & stim_v_i;
                stim_ready_o = en_i & ready_i;
                stim_fire    = en_i & stim_v_i & ready_i;
                if (stim_fire) begin
                    tx_count_d = tx_count_q + 1'b1;
                    if (tx_count_q == tx_w_lp'(num_tx_p - 1)) begin
                        state_d = RECV;
                        timer_d = '0;
                    end
                end
            end

            RECV: begin
                // A response and its expected word must leave together, so
                // both ready signals share the same qualifier.
                resp_fire   = en_i & v_i & exp_v_i;
                yumi_o      = resp_fire;
                exp_ready_o = resp_fire;
                if (resp_fire) begin
                    rx_count_d = rx_count_q + 1'b1;
                    timer_d    = '0;
                    if (mismatch && (err_q != 16'hFFFF)) begin
                        err_d = err_q + 16'd1;
                    end
                    if (rx_count_q == rx_w_lp'(num_rx_p - 1)) begin
                        state_d = DONE;
                    end
                end else if (en_i) begin
                    timer_d = timer_q + 1'b1;
                    if (timer_q == tmo_w_lp'(timeout_p - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = DONE;
                    end
                end
            end

            DONE: begin
                // Terminal until reset; all handshakes stay low.
            end

            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Status outputs
    // -------------------------------------------------------------------------
    assign done_o        = (state_q == DONE);
    assign pass_o        = done_o & (err_q == 16'd0) & ~timeout_q;
    assign timeout_o     = timeout_q;
    assign error_count_o = err_q;

endmodule

// File: doc/bsg_test_node_master.md
BSG_TEST_NODE_MASTER -- requirements
Module: bsg_test_node_master

Interface
REQ-001 Parameter ring_width_p, default 80, ring packet width; SHALL be >= 79.
REQ-002 Parameter client_id_p, default 0, 4-bit destination/source client ID checked and inserted at packet bits [78:75].
REQ-003 Parameter num_tx_p, default 64, number of stimulus words sent per test (>= 1).
REQ-004 Parameter num_rx_p, default 64, number of responses expected per test (>= 1).
REQ-005 Parameter timeout_p, default 4096, maximum idle cycles allowed between responses (>= 1).
REQ-006 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-007 Port clk_i, input, 1, sole clock.
REQ-008 Port reset_n_i, input, 1, asynchronous active-low reset.
REQ-009 Port en_i, input, 1, global enable; low freezes all state and deasserts all handshake outputs.
REQ-010 Ports stim_v_i / stim_data_i / stim_ready_o, in/in/out, 1/75/1, host stimulus stream (valid-ready).
REQ-011 Ports exp_v_i / exp_data_i / exp_ready_o, in/in/out, 1/75/1, host expected-response stream (valid-ready).
REQ-012 Ports v_o / data_o / ready_i, out/out/in, 1/ring_width_p/1, packets toward client (valid-ready; transfer on v_o & ready_i).
REQ-013 Ports v_i / data_i / yumi_o, in/in/out, 1/ring_width_p/1, packets from client (valid-yumi; yumi_o only when v_i high).
REQ-014 Ports done_o, pass_o, timeout_o, out, 1 each, test status; error_count_o, out, 16, mismatch count.

Function
REQ-015 FSM states SHALL be IDLE, SEND, RECV, DONE; register encoding, one state register.
REQ-016 IDLE -> SEND on en_i high; no other IDLE exit.
REQ-017 In SEND: v_o = en_i & stim_v_i; stim_ready_o = en_i & ready_i; data_o = {zeros, client_id_p[3:0], stim_data_i}; combinational pass-through, zero latency.
REQ-018 tx counter SHALL increment on each stim transfer; SEND -> RECV in the cycle after the transfer bringing count to num_tx_p.
REQ-019 In RECV: yumi_o = exp_ready_o = en_i & v_i & exp_v_i; response and expected word SHALL be consumed in the same cycle, never one without the other.
REQ-020 On each accepted response, mismatch = (data_i[74:0] != exp_data_i) | (data_i[78:75] != client_id_p); mismatch increments error_count_o, saturating at 16'hFFFF.
REQ-021 rx counter increments per accepted response; RECV -> DONE on the transfer reaching num_rx_p.
REQ-022 Timeout counter SHALL clear on entry to RECV and on each accepted response, increment each enabled RECV cycle otherwise; reaching timeout_p SHALL set timeout_o and go to DONE.
REQ-023 Bits data_o[ring_width_p-1:79] SHALL be zero; data_i bits above 78 are ignored.
REQ-024 Outside SEND: v_o = 0, stim_ready_o = 0; outside RECV: yumi_o = 0, exp_ready_o = 0.
REQ-025 DONE is terminal until reset: done_o = 1; pass_o = (error_count_o == 0) & ~timeout_o; all handshakes low.
REQ-026 Responses arriving during SEND SHALL be held (yumi_o low), not dropped.
REQ-027 en_i low in any state SHALL hold counters, timeout counter and state unchanged.

Reset
REQ-028 reset_n_i low SHALL asynchronously force IDLE, all counters 0, error_count_o 0, done_o/pass_o/timeout_o 0, v_o/stim_ready_o/yumi_o/exp_ready_o 0.
REQ-029 Reset asserted mid-SEND or mid-RECV SHALL abort the test; no partial status is retained.
REQ-030 Deassertion SHALL be synchronous to clk_i; first state change occurs no earlier than the first rising edge after release.

Verification
REQ-031 num_tx_p=num_rx_p=4, ready_i=1, responses equal expected -> 4 packets out with bits[78:75]=client_id_p, done_o=1, pass_o=1, error_count_o=0.
REQ-032 Response 2 payload differs by one bit -> done_o=1, error_count_o=1, pass_o=0.
REQ-033 Response with correct payload but ID field = client_id_p+1 -> error_count_o=1, pass_o=0.
REQ-034 timeout_p=8, only 3 of 4 responses supplied -> timeout_o=1, done_o=1, pass_o=0 exactly 8 enabled cycles after third response.
REQ-035 ready_i toggled randomly, en_i dropped 5 cycles mid-SEND -> no stimulus word lost or duplicated; counters frozen while en_i low.
REQ-036 reset_n_i pulsed low during RECV -> all outputs 0 immediately (no clock edge required), FSM restarts from IDLE.
